// File: rtl/can_pkg.sv
// Shared CAN frame constants: FSM state encodings, field lengths, stuffing limit
// and small helpers used by the frame transmitter.
package can_pkg;

  localparam int CNT_W = 7;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_SOF      = 4'd1;
  localparam logic [3:0] ST_ARB      = 4'd2;
  localparam logic [3:0] ST_CTRL     = 4'd3;
  localparam logic [3:0] ST_DATA     = 4'd4;
  localparam logic [3:0] ST_CRC      = 4'd5;
  localparam logic [3:0] ST_CRC_DEL  = 4'd6;
  localparam logic [3:0] ST_ACK_SLOT = 4'd7;
  localparam logic [3:0] ST_ACK_DEL  = 4'd8;
  localparam logic [3:0] ST_EOF      = 4'd9;
  localparam logic [3:0] ST_IFS      = 4'd10;

  localparam cnt_t ID_LEN   = 7'd11;
  localparam cnt_t ARB_LEN  = ID_LEN + 7'd1;
  localparam cnt_t DLC_LEN  = 7'd4;
  localparam cnt_t CTRL_LEN = 7'd2 + DLC_LEN;
  localparam cnt_t CRC_LEN  = 7'd15;
  localparam cnt_t EOF_LEN  = 7'd7;
  localparam cnt_t IFS_LEN  = 7'd3;

  localparam logic [2:0] STUFF_LIMIT = 3'd5;

  // DLC values above 8 still carry a full 8-byte payload.
  function automatic cnt_t data_len(input logic [3:0] dlc);
    return (dlc > 4'd8) ? 7'd64 : {dlc, 3'b000};
  endfunction

  function automatic logic in_stuff_region(input logic [3:0] st);
    return st inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC};
  endfunction

endpackage

// File: rtl/can_crc.sv
// CAN CRC-15 generator (polynomial 0x4599), one bit per enable, MSB-first input.
module can_crc (
  input  logic        clk,
  input  logic        data,
  input  logic        enable,
  input  logic        initialize,
  output logic [14:0] crc
);

  logic w_fb;

  assign w_fb = data ^ crc[14];

  always_ff @(posedge clk) begin
    if (initialize) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[13:0], 1'b0} ^ (w_fb ? 15'h4599 : 15'h0000);
    end
  end

endmodule

// File: rtl/can_tx_frame.sv
// CAN 2.0A data-frame transmitter: serialises one frame per accepted start,
// bit-stuffing SOF..CRC and advancing one bit per bit_tick.
module can_tx_frame
  import can_pkg::*;
#(
  parameter int BIT_TICK_MIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_tick,
  input  logic        start,
  input  logic [10:0] id,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  input  logic        rx,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        ack_err
);

  logic [3:0]  r_state;
  cnt_t        r_cnt;
  logic [10:0] r_id;
  logic [3:0]  r_dlc;
  logic [63:0] r_data;
  logic [2:0]  r_stuff_cnt;
  logic        r_last;
  logic        r_tx;
  logic        r_busy;
  logic        r_done;
  logic        r_ack_err;
  logic [7:0]  r_gap;

  logic [3:0]  w_next_state;
  cnt_t        w_next_cnt;
  logic        w_next_bit;
  logic        w_accept;
  logic        w_do_stuff;
  logic        w_crc_en;
  logic [14:0] w_crc;

  assign w_accept   = (r_state == ST_IDLE) && !r_busy && start;
  assign w_do_stuff = in_stuff_region(r_state) && (r_stuff_cnt == STUFF_LIMIT);
  assign w_crc_en   = bit_tick && r_busy && !w_do_stuff &&
                      (w_next_state inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA});

  // r_state/r_cnt name the bit currently on the wire; this picks the next one.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt + 7'd1;
    case (r_state)
      ST_IDLE:     begin w_next_state = ST_SOF; w_next_cnt = '0; end
      ST_SOF:      begin w_next_state = ST_ARB; w_next_cnt = '0; end
      ST_ARB:      if (r_cnt == ARB_LEN - 7'd1) begin w_next_state = ST_CTRL; w_next_cnt = '0; end
      ST_CTRL:     if (r_cnt == CTRL_LEN - 7'd1) begin
                     w_next_state = (r_dlc == 4'd0) ? ST_CRC : ST_DATA;
                     w_next_cnt   = '0;
                   end
      ST_DATA:     if (r_cnt == data_len(r_dlc) - 7'd1) begin w_next_state = ST_CRC; w_next_cnt = '0; end
      ST_CRC:      if (r_cnt == CRC_LEN - 7'd1) begin w_next_state = ST_CRC_DEL; w_next_cnt = '0; end
      ST_CRC_DEL:  begin w_next_state = ST_ACK_SLOT; w_next_cnt = '0; end
      ST_ACK_SLOT: begin w_next_state = ST_ACK_DEL; w_next_cnt = '0; end
      ST_ACK_DEL:  begin w_next_state = ST_EOF; w_next_cnt = '0; end
      ST_EOF:      if (r_cnt == EOF_LEN - 7'd1) begin w_next_state = ST_IFS; w_next_cnt = '0; end
      ST_IFS:      if (r_cnt == IFS_LEN - 7'd1) begin w_next_state = ST_IDLE; w_next_cnt = '0; end
      default:     begin w_next_state = ST_IDLE; w_next_cnt = '0; end
    endcase
  end

  always_comb begin
    w_next_bit = 1'b1;
    case (w_next_state)
      ST_SOF:  w_next_bit = 1'b0;
      ST_ARB:  w_next_bit = (w_next_cnt < ID_LEN) ? r_id[4'(ID_LEN - 7'd1 - w_next_cnt)] : 1'b0;
      ST_CTRL: w_next_bit = (w_next_cnt < 7'd2) ? 1'b0 : r_dlc[2'(CTRL_LEN - 7'd1 - w_next_cnt)];
      ST_DATA: w_next_bit = r_data[6'(7'd63 - w_next_cnt)];
      ST_CRC:  w_next_bit = w_crc[4'(CRC_LEN - 7'd1 - w_next_cnt)];
      default: w_next_bit = 1'b1;
    endcase
  end

  can_crc u_crc (
    .clk        (clk),
    .data       (w_next_bit),
    .enable     (w_crc_en),
    .initialize (w_accept),
    .crc        (w_crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_id        <= '0;
      r_dlc       <= '0;
      r_data      <= '0;
      r_stuff_cnt <= '0;
      r_last      <= 1'b1;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ack_err   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      if (w_accept) begin
        r_busy <= 1'b1;
        r_id   <= id;
        r_dlc  <= dlc;
        r_data <= data;
      end else if (bit_tick && r_busy) begin
        if (w_do_stuff) begin
          // Stuff bit holds the field position and opens a new run.
          r_tx        <= ~r_last;
          r_last      <= ~r_last;
          r_stuff_cnt <= 3'd1;
        end else begin
          r_state <= w_next_state;
          r_cnt   <= w_next_cnt;
          r_tx    <= w_next_bit;
          if (in_stuff_region(w_next_state)) begin
            r_last      <= w_next_bit;
            r_stuff_cnt <= (w_next_bit == r_last) ? r_stuff_cnt + 3'd1 : 3'd1;
          end else begin
            r_last      <= 1'b1;
            r_stuff_cnt <= '0;
          end
          if (r_state == ST_ACK_SLOT) r_ack_err <= rx;
          if ((r_state == ST_IFS) && (w_next_state == ST_IDLE)) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap <= '1;
    end else if (bit_tick) begin
      r_gap <= 8'd1;
    end else if (r_gap != '1) begin
      r_gap <= r_gap + 8'd1;
    end
  end

  ap_tick_spacing: assert property (@(posedge clk) disable iff (!rst_n)
    bit_tick |-> (int'(r_gap) >= BIT_TICK_MIN));

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ack_err;

endmodule

// File: tb/tb_can_tx_frame.sv
// Directed self-checking bench for can_tx_frame: builds each expected frame
// from its fields and compares the serialised tx stream bit by bit.
module tb_can_tx_frame;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_tick = 1'b0;
  logic        start = 1'b0;
  logic [10:0] id = '0;
  logic [3:0]  dlc = '0;
  logic [63:0] data = '0;
  logic        rx = 1'b0;
  logic        tx, busy, done, ack_err;

  logic        ref_data = 1'b0;
  logic        ref_en = 1'b0;
  logic        ref_init = 1'b0;
  logic [14:0] ref_crc;

  int checks = 0;
  int errors = 0;

  bit raw_q[$];
  bit exp_q[$];
  bit got_q[$];
  bit dq[$];
  logic [14:0] exp_crc;
  bit crc_end_stuffed;
  int ack_cnt, ack_idx, done_idx;
  bit busy_ok;

  can_tx_frame #(.BIT_TICK_MIN(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_tick (bit_tick),
    .start    (start),
    .id       (id),
    .dlc      (dlc),
    .data     (data),
    .rx       (rx),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err)
  );

  can_crc u_ref (
    .clk        (clk),
    .data       (ref_data),
    .enable     (ref_en),
    .initialize (ref_init),
    .crc        (ref_crc)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      bit_tick = 1'b1;
      @(negedge clk);
      bit_tick = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  function automatic logic [14:0] crc15_step(input logic [14:0] c, input logic b);
    logic fb;
    fb = b ^ c[14];
    c = {c[13:0], 1'b0};
    if (fb) c = c ^ 15'h4599;
    return c;
  endfunction

  task automatic build_raw(input logic [10:0] i, input logic [3:0] d, input logic [63:0] p);
    int n;
    raw_q.delete();
    raw_q.push_back(1'b0);
    for (int k = 10; k >= 0; k--) raw_q.push_back(i[k]);
    repeat (3) raw_q.push_back(1'b0);
    for (int k = 3; k >= 0; k--) raw_q.push_back(d[k]);
    n = (d > 4'd8) ? 64 : int'(d) * 8;
    for (int k = 0; k < n; k++) raw_q.push_back(p[63-k]);
  endtask

  task automatic build_exp();
    bit seq[$];
    logic [14:0] c;
    bit last;
    int run;
    c = '0;
    foreach (raw_q[k]) c = crc15_step(c, raw_q[k]);
    exp_crc = c;
    seq = raw_q;
    for (int k = 14; k >= 0; k--) seq.push_back(c[k]);
    exp_q.delete();
    last = 1'b1;
    run = 0;
    crc_end_stuffed = 1'b0;
    for (int k = 0; k < seq.size(); k++) begin
      exp_q.push_back(seq[k]);
      if (seq[k] == last) run++;
      else begin run = 1; last = seq[k]; end
      if (run == 5) begin
        exp_q.push_back(!seq[k]);
        last = !seq[k];
        run = 1;
        if (k == seq.size() - 1) crc_end_stuffed = 1'b1;
      end
    end
    repeat (13) exp_q.push_back(1'b1);
  endtask

  task automatic destuff(input int n);
    bit last;
    int run;
    bit skip;
    last = 1'b1;
    run = 0;
    skip = 1'b0;
    dq.delete();
    for (int k = 0; k < n; k++) begin
      if (skip) begin
        skip = 1'b0;
        last = got_q[k];
        run = 1;
      end else begin
        dq.push_back(got_q[k]);
        if (got_q[k] == last) run++;
        else begin run = 1; last = got_q[k]; end
        if (run == 5) skip = 1'b1;
      end
    end
  endtask

  // -1 when got_q equals exp_q, otherwise first differing (or missing) bit index.
  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) if (got_q[k] !== exp_q[k]) return k;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic send(input logic [10:0] i, input logic [3:0] d, input logic [63:0] p,
                      input bit release_rst);
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    id = i;
    dlc = d;
    data = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    build_raw(i, d, p);
    build_exp();
  endtask

  task automatic capture(input int start_at, input int abort_at, output bit aborted);
    int ticks;
    bit fin;
    ticks = 0;
    fin = 1'b0;
    aborted = 1'b0;
    got_q.delete();
    ack_cnt = 0;
    ack_idx = -1;
    done_idx = -1;
    busy_ok = 1'b1;
    while (!fin && ticks < 400) begin
      @(posedge clk);
      if (bit_tick) begin
        ticks++;
        @(negedge clk);
        if (ack_err) begin ack_cnt++; ack_idx = got_q.size(); end
        if (done) begin
          done_idx = got_q.size();
          fin = 1'b1;
          if (busy) busy_ok = 1'b0;
        end else begin
          got_q.push_back(tx);
          if (!busy) busy_ok = 1'b0;
        end
        if (!fin && got_q.size() == start_at) begin
          id = 11'h7FF;
          dlc = 4'd1;
          data = '1;
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
        if (!fin && got_q.size() == abort_at) begin
          #2 rst_n = 1'b0;
          aborted = 1'b1;
          fin = 1'b1;
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done after %0d bit ticks, required done pulse", ticks);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b required 0", ack_err); end
    $display("reset: tx=%b busy=%b done=%b ack_err=%b", tx, busy, done, ack_err);
  endtask

  task automatic test_zero_frame();
    bit ab;
    int d;
    logic [21:0] head;
    logic [21:0] head_exp;
    head_exp = 22'b0000010000010000010000;
    send(11'h000, 4'd0, 64'h0, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_cycle_start: busy %b required 1", busy); end
    capture(-1, -1, ab);
    head = '0;
    for (int k = 0; k < 22 && k < got_q.size(); k++) head = {head[20:0], got_q[k]};
    checks++; if (head !== head_exp) begin errors++; $display("FAIL zero_head: got %b required %b", head, head_exp); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL zero_frame: len %0d required %0d, first diff bit %0d", got_q.size(), exp_q.size(), d); end
    checks++; if (done_idx != exp_q.size()) begin errors++; $display("FAIL zero_done: at bit %0d required %0d", done_idx, exp_q.size()); end
    checks++; if (!busy_ok) begin errors++; $display("FAIL zero_busy: busy wrong during frame or at done, required high then low"); end
    checks++; if (ack_cnt != 0) begin errors++; $display("FAIL zero_ack: %0d ack_err pulses required 0", ack_cnt); end
    $display("frame id=000 dlc=0: %0d bits, done at %0d", got_q.size(), done_idx);
  endtask

  task automatic test_crc_123();
    bit ab;
    int d;
    logic [14:0] got_crc;
    send(11'h123, 4'd2, {16'hA55A, 48'h0}, 1'b0);
    capture(-1, -1, ab);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL crc123_frame: len %0d required %0d, first diff bit %0d", got_q.size(), exp_q.size(), d); end
    destuff(got_q.size() - 13);
    checks++; if (dq.size() != 50) begin errors++; $display("FAIL crc123_len: destuffed %0d bits required 50", dq.size()); end
    got_crc = '0;
    for (int k = 35; k < 50 && k < dq.size(); k++) got_crc = {got_crc[13:0], dq[k]};
    @(negedge clk); ref_init = 1'b1;
    @(negedge clk); ref_init = 1'b0;
    foreach (raw_q[k]) begin ref_data = raw_q[k]; ref_en = 1'b1; @(negedge clk); end
    ref_en = 1'b0;
    checks++; if (got_crc !== ref_crc) begin errors++; $display("FAIL crc123_ref: got %h required %h", got_crc, ref_crc); end
    checks++; if (got_crc !== exp_crc) begin errors++; $display("FAIL crc123_model: got %h required %h", got_crc, exp_crc); end
    checks++; if (done_idx != exp_q.size()) begin errors++; $display("FAIL crc123_done: at bit %0d required %0d", done_idx, exp_q.size()); end
    $display("frame id=123 dlc=2: %0d bits, crc %h", got_q.size(), got_crc);
  endtask

  task automatic test_ack_err();
    bit ab;
    int d;
    rx = 1'b1;
    send(11'h2AB, 4'd1, {8'hC3, 56'h0}, 1'b0);
    capture(-1, -1, ab);
    rx = 1'b0;
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL ack_frame: len %0d required %0d, first diff bit %0d", got_q.size(), exp_q.size(), d); end
    checks++; if (ack_cnt != 1) begin errors++; $display("FAIL ack_count: %0d pulses required 1", ack_cnt); end
    checks++; if (ack_idx != exp_q.size() - 11) begin errors++; $display("FAIL ack_pos: at bit %0d required %0d", ack_idx, exp_q.size() - 11); end
    checks++; if (done_idx != exp_q.size()) begin errors++; $display("FAIL ack_done: at bit %0d required %0d", done_idx, exp_q.size()); end
    $display("frame id=2AB rx=1: ack_err at %0d, done at %0d", ack_idx, done_idx);
  endtask

  task automatic test_busy_start();
    bit ab;
    int d;
    send(11'h0F0, 4'd12, 64'h0123456789ABCDEF, 1'b0);
    capture(20, -1, ab);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL busy_frame: len %0d required %0d, first diff bit %0d", got_q.size(), exp_q.size(), d); end
    destuff(got_q.size() - 13);
    checks++; if (dq.size() != 19 + 64 + 15) begin errors++; $display("FAIL dlc12_len: destuffed %0d bits required %0d", dq.size(), 19 + 64 + 15); end
    checks++; if (done_idx != exp_q.size()) begin errors++; $display("FAIL busy_done: at bit %0d required %0d", done_idx, exp_q.size()); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after: busy %b required 0 (mid-frame start ignored)", busy); end
    $display("frame id=0F0 dlc=12 with mid-frame start: %0d bits", got_q.size());
  endtask

  task automatic test_reset_mid();
    bit ab;
    int d;
    send(11'h3A5, 4'd8, 64'hFEDCBA9876543210, 1'b0);
    capture(-1, 30, ab);
    checks++; if (!ab) begin errors++; $display("FAIL mid_reach: reset point not reached, required bit 30"); end
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL mid_rst_tx: got %b required 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
    repeat (4) @(negedge clk);
    checks++; if (done !== 1'b0 || ack_err !== 1'b0) begin errors++; $display("FAIL mid_rst_pulses: done %b ack_err %b required 0 0", done, ack_err); end
    send(11'h3A5, 4'd8, 64'hFEDCBA9876543210, 1'b1);
    capture(-1, -1, ab);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL mid_frame: len %0d required %0d, first diff bit %0d", got_q.size(), exp_q.size(), d); end
    checks++; if (done_idx != exp_q.size()) begin errors++; $display("FAIL mid_done: at bit %0d required %0d", done_idx, exp_q.size()); end
    $display("frame id=3A5 after mid-frame reset: %0d bits", got_q.size());
  endtask

  task automatic test_crc_stuff();
    logic [10:0] sid;
    logic [15:0] sdat;
    logic [14:0] pre, c, got_crc;
    bit found, ab, ones;
    int d, n;
    found = 1'b0;
    sid = '0;
    sdat = '0;
    for (int t = 0; t < 64 && !found; t++) begin
      sid = 11'h555 ^ 11'(t);
      build_raw(sid, 4'd2, 64'h0);
      pre = '0;
      for (int k = 0; k < 19; k++) pre = crc15_step(pre, raw_q[k]);
      for (int v = 0; v < 65536 && !found; v++) begin
        c = pre;
        for (int b = 15; b >= 0; b--) c = crc15_step(c, v[b]);
        if (c == 15'h7FFF) begin
          build_raw(sid, 4'd2, {16'(v), 48'h0});
          build_exp();
          if (crc_end_stuffed) begin found = 1'b1; sdat = 16'(v); end
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stuff_search: no all-ones CRC vector found, required one");
    end else begin
      send(sid, 4'd2, {sdat, 48'h0}, 1'b0);
      capture(-1, -1, ab);
      n = got_q.size();
      d = first_diff();
      checks++; if (d != -1) begin errors++; $display("FAIL stuff_frame: len %0d required %0d, first diff bit %0d", n, exp_q.size(), d); end
      ones = (n >= 19);
      for (int k = n - 19; k <= n - 15 && k >= 0; k++) if (got_q[k] !== 1'b1) ones = 1'b0;
      checks++; if (!ones) begin errors++; $display("FAIL stuff_run: last five CRC bits not all 1, required 11111"); end
      checks++; if (n < 14 || got_q[n-14] !== 1'b0) begin errors++; $display("FAIL stuff_bit: bit before CRC_DEL is %b required 0", (n >= 14) ? got_q[n-14] : 1'b1); end
      destuff(n - 13);
      got_crc = '0;
      for (int k = 35; k < 50 && k < dq.size(); k++) got_crc = {got_crc[13:0], dq[k]};
      checks++; if (got_crc !== 15'h7FFF) begin errors++; $display("FAIL stuff_crc: got %h required 7fff", got_crc); end
      $display("frame id=%h data=%h: crc %h, %0d bits", sid, sdat, got_crc, n);
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_crc_123();
    test_ack_err();
    test_busy_start();
    test_reset_mid();
    test_crc_stuff();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
